// File: rtl/ext_mem_ctrl.sv
// Word-addressed external-memory front-end for the DMA: one read or write at a time,
// programmable response latency, backdoor preload port, sticky out-of-range flag.
module ext_mem_ctrl #(
  parameter  int DEPTH  = 65536,
  parameter  int RD_LAT = 4,
  parameter  int WR_LAT = 2,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r_request_extmem,
  input  logic          w_request_extmem,
  input  logic [31:0]   addr_extmem,
  input  logic [31:0]   w_data_extmem,
  output logic          r_valid_extmem,
  output logic [31:0]   data_extmem,
  output logic          w_ack_extmem,
  output logic          busy,
  output logic          err_addr,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data
);

  localparam int CW = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    RD_RESP = 3'd2,
    WR_WAIT = 3'd3,
    WR_ACK  = 3'd4
  } state_t;

  state_t         state_r, state_s;
  logic [CW-1:0]  cnt_r, cnt_s;
  logic [AW-1:0]  addr_r;
  logic [31:0]    wdata_r;
  logic           oor_r;
  logic [31:0]    mem [DEPTH];

  logic           r_valid_r, w_ack_r, busy_r, err_r;
  logic [31:0]    data_r;

  logic           req_oor_s;
  logic           accept_s;
  logic           load_rd_s;
  logic [AW-1:0]  rd_idx_s;
  logic           rd_oor_s;
  logic           mem_we_s;
  logic           ld_we_s;
  logic           r_valid_s, w_ack_s, busy_s;

  assign req_oor_s = |addr_extmem[31:AW];

  // State register plus latched transaction context
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      addr_r  <= '0;
      wdata_r <= 32'h0;
      oor_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (accept_s) begin
        addr_r  <= addr_extmem[AW-1:0];
        wdata_r <= w_data_extmem;
        oor_r   <= req_oor_s;
      end
    end
  end

  // Next-state logic; the wait states leave when the counter would reach zero
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (r_request_extmem) begin
          state_s = (RD_LAT == 1) ? RD_RESP : RD_WAIT;
          cnt_s   = CW'(RD_LAT - 1);
        end else if (w_request_extmem) begin
          state_s = (WR_LAT == 1) ? WR_ACK : WR_WAIT;
          cnt_s   = CW'(WR_LAT - 1);
        end else begin
          state_s = IDLE;
        end
      end
      RD_WAIT: begin
        if (!r_request_extmem) begin
          state_s = IDLE;
          cnt_s   = '0;
        end else if (cnt_r <= CW'(1)) begin
          state_s = RD_RESP;
          cnt_s   = '0;
        end else begin
          cnt_s   = cnt_r - CW'(1);
        end
      end
      WR_WAIT: begin
        if (!w_request_extmem) begin
          state_s = IDLE;
          cnt_s   = '0;
        end else if (cnt_r <= CW'(1)) begin
          state_s = WR_ACK;
          cnt_s   = '0;
        end else begin
          cnt_s   = cnt_r - CW'(1);
        end
      end
      RD_RESP: state_s = IDLE;
      WR_ACK:  state_s = IDLE;
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  // Output and datapath control decode
  always_comb begin
    accept_s  = (state_r == IDLE) && (r_request_extmem || w_request_extmem);
    load_rd_s = (state_s == RD_RESP) && (state_r != RD_RESP);
    if (state_r == IDLE) begin
      rd_idx_s = addr_extmem[AW-1:0];
      rd_oor_s = req_oor_s;
    end else begin
      rd_idx_s = addr_r;
      rd_oor_s = oor_r;
    end
    mem_we_s  = (state_r == WR_ACK) && !oor_r;
    ld_we_s   = (state_r == IDLE) && ld_en && !r_request_extmem && !w_request_extmem;
    r_valid_s = (state_s == RD_RESP);
    w_ack_s   = (state_s == WR_ACK);
    busy_s    = (state_s != IDLE);
  end

  // Registered outputs; read data captured on entry to RD_RESP and held afterwards
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid_r <= 1'b0;
      w_ack_r   <= 1'b0;
      busy_r    <= 1'b0;
      err_r     <= 1'b0;
      data_r    <= 32'h0;
    end else begin
      r_valid_r <= r_valid_s;
      w_ack_r   <= w_ack_s;
      busy_r    <= busy_s;
      if (accept_s && req_oor_s) begin
        err_r <= 1'b1;
      end
      if (load_rd_s) begin
        data_r <= rd_oor_s ? 32'h0 : mem[rd_idx_s];
      end
    end
  end

  // Storage array: committed writes and backdoor preload, never reset
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[addr_r] <= wdata_r;
    end else if (ld_we_s) begin
      mem[ld_addr] <= ld_data;
    end
  end

  assign r_valid_extmem = r_valid_r;
  assign w_ack_extmem   = w_ack_r;
  assign busy           = busy_r;
  assign err_addr       = err_r;
  assign data_extmem    = data_r;

endmodule
